// File: rtl/lift_mem_responder.sv
// Banked word store for the lift controller bus with a host preload/readback port.
// Reads are registered (1 cycle). The lift controller takes priority while busy and the host is stalled.
module lift_mem_responder #(
  parameter int NUM_PROC = 7,
  parameter int NUM_MEM  = 4,
  parameter int DEPTH    = 512,
  parameter int DATA_W   = 240,
  parameter int ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lift_busy,
  input  logic [2:0]        lift_proc_sel,
  input  logic [3:0]        lift_mem_sel,
  input  logic [ADDR_W-1:0] lift_addr,
  input  logic              lift_we,
  input  logic [DATA_W-1:0] lift_wdata,
  output logic [DATA_W-1:0] lift_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [2:0]        host_proc,
  input  logic [3:0]        host_mem,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ready,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              sel_err,
  output logic [15:0]       lift_wr_cnt
);

  localparam int NUM_BANK = NUM_PROC * NUM_MEM;
  localparam int IDX_W    = $clog2(NUM_BANK);

  typedef enum logic {OWN_HOST, OWN_LIFT} owner_t;

  owner_t state, state_nxt;

  logic              lift_own;
  logic              host_acc;
  logic              host_rd;
  logic              acc_active;
  logic [2:0]        sel_proc;
  logic [3:0]        sel_mem;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_ok;
  logic [IDX_W-1:0]  sel_idx;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              lift_wr;
  logic [DATA_W-1:0] rd_word;

  logic [DATA_W-1:0] bank_mem [NUM_BANK][DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= OWN_HOST;
    else     state <= state_nxt;
  end

  // Owner for the current cycle is the state entered at the coming edge,
  // so lift_busy takes effect in the same cycle it is presented.
  always_comb begin
    state_nxt = state;
    case (state)
      OWN_HOST: if (lift_busy)  state_nxt = OWN_LIFT;
      OWN_LIFT: if (!lift_busy) state_nxt = OWN_HOST;
      default:  state_nxt = OWN_HOST;
    endcase
    lift_own   = (state_nxt == OWN_LIFT);
    host_ready = host_req & ~lift_own;
    host_acc   = host_ready;
    host_rd    = host_acc & ~host_we;
    acc_active = lift_own | host_acc;
  end

  always_comb begin
    sel_proc = lift_own ? lift_proc_sel : host_proc;
    sel_mem  = lift_own ? lift_mem_sel  : host_mem;
    sel_addr = lift_own ? lift_addr     : host_addr;
    wr_data  = lift_own ? lift_wdata    : host_wdata;
    sel_ok   = (int'(sel_proc) < NUM_PROC) && (int'(sel_mem) < NUM_MEM);
    sel_idx  = IDX_W'(int'(sel_proc) * NUM_MEM + int'(sel_mem));
    lift_wr  = lift_own & lift_we & sel_ok;
    wr_en    = sel_ok & (lift_own ? lift_we : (host_acc & host_we));
  end

  assign rd_word = bank_mem[sel_idx][sel_addr];

  // Storage is not reset; the write lands at the same edge that captures the
  // old word into the read registers, giving read-first behaviour.
  always_ff @(posedge clk) begin
    if (wr_en) bank_mem[sel_idx][sel_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lift_rdata  <= '0;
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
      sel_err     <= 1'b0;
      lift_wr_cnt <= '0;
    end else begin
      host_rvalid <= host_rd;
      if (lift_own) lift_rdata <= sel_ok ? rd_word : '0;
      if (host_rd)  host_rdata <= sel_ok ? rd_word : '0;
      if (acc_active && !sel_ok) sel_err <= 1'b1;
      if (lift_wr && lift_wr_cnt != 16'hFFFF) lift_wr_cnt <= lift_wr_cnt + 16'd1;
    end
  end

endmodule
